fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, default widths, NOP encoding.
package fetch_stage_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc with load, hold and clear (clear wins over load).
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] instr_d,
    input  logic [ADDR_W-1:0] pc_d,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc
);
    logic              valid_reg;
    logic [DATA_W-1:0] instr_reg;
    logic [ADDR_W-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= 1'b0;
            instr_reg <= DATA_W'(NOP_INSTR);
            pc_reg    <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
            instr_reg <= DATA_W'(NOP_INSTR);
            pc_reg    <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= instr_d;
            pc_reg    <= pc_d;
        end
    end

    assign valid = valid_reg;
    assign instr = instr_reg;
    assign pc    = pc_reg;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register, flush/stall handling.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              stall,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] req_pc_reg;
    logic              req_valid_reg;
    logic              drop_reg;
    logic              load;

    // A response is delivered only if no flush hit this transaction, including one in this cycle.
    assign load = (state_reg == S_WAIT) && imem_rsp_valid && !drop_reg && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            req_pc_reg    <= '0;
            req_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    req_pc_reg    <= pc_in;
                    req_valid_reg <= 1'b1;
                    state_reg     <= S_REQ;
                end
                S_REQ: begin
                    // The request is never withdrawn; a flush only marks its response for discard.
                    if (flush)
                        drop_reg <= 1'b1;
                    if (imem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_reg <= 1'b0;
                        if (load && stall) begin
                            state_reg <= S_HOLD;
                        end else begin
                            req_pc_reg    <= pc_in;
                            req_valid_reg <= 1'b1;
                            state_reg     <= S_REQ;
                        end
                    end else if (flush) begin
                        drop_reg <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (flush || !stall) begin
                        req_pc_reg    <= pc_in;
                        req_valid_reg <= 1'b1;
                        state_reg     <= S_REQ;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign imem_req_valid = req_valid_reg;
    assign imem_addr      = req_pc_reg;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .clear   (flush),
        .instr_d (imem_rsp_data),
        .pc_d    (req_pc_reg),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (load)
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            if ((state_reg == S_HOLD) && stall && !flush)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_reg;
    assign perf_stall_cnt = stall_cnt_reg;
`else
    // Counters and their ports are absent in this build.
`endif
endmodule
